// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4 memory slave with INCR/FIXED bursts, post-reset pattern fill
// and a backdoor port for preloading and inspecting the word array.
module axi4_slave_mem #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                ID_W      = 1,
  parameter int                MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] FILL      = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic              bd_en,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [DATA_W-1:0] bd_wdata,
  input  logic [3:0]        bd_wstrb,
  output logic [DATA_W-1:0] bd_rdata,
  output logic              init_done
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = IW + 1;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // The extra top bit of the subtraction is the borrow, i.e. addr below BASE_ADDR.
  function automatic logic in_rng(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return !off[ADDR_W] && ((off[ADDR_W-1:0] >> 2) < ADDR_W'(MEM_WORDS));
  endfunction

  function automatic logic [IW-1:0] widx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return off[IW+1:2];
  endfunction

  function automatic logic legal(input logic [2:0] size, input logic [1:0] burst);
    return !burst[1] && size <= 3'd2;
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [2:0] size,
                                                  input logic [1:0] burst);
    return burst == 2'b01 ? a + (ADDR_W'(1) << size) : a;
  endfunction

  typedef enum logic [1:0] {W_FILL, W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_FILL, R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  w_state_t          w_q;
  r_state_t          r_q;
  logic [CW-1:0]     fill_cnt_q;
  logic              init_done_q;
  logic [DATA_W-1:0] bd_rdata_q;
  logic              awready_q, wready_q, bvalid_q, werr_q;
  logic [1:0]        bresp_q;
  logic [ID_W-1:0]   bid_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [7:0]        wlen_q, wcnt_q;
  logic [2:0]        wsize_q;
  logic [1:0]        wburst_q;
  logic              arready_q, rvalid_q, rlast_q;
  logic [1:0]        rresp_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [7:0]        rlen_q, rcnt_q;
  logic [2:0]        rsize_q;
  logic [1:0]        rburst_q;

  logic fill_done, bd_rd, bd_wr, w_beat, w_end, w_ok, w_bad, r_ok;
  logic              mem_we;
  logic [IW-1:0]     mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [3:0]        mem_ws;

  assign fill_done = fill_cnt_q == CW'(MEM_WORDS);
  assign bd_rd     = bd_en && !bd_we && init_done_q;
  assign bd_wr     = bd_en && bd_we && init_done_q;
  assign w_beat    = wvalid && wready;
  assign w_end     = wcnt_q == wlen_q;
  assign w_ok      = legal(wsize_q, wburst_q) && in_rng(waddr_q);
  assign w_bad     = !w_ok || (wlast != w_end);
  assign r_ok      = legal(rsize_q, rburst_q) && in_rng(raddr_q);

  assign awready   = awready_q;
  assign wready    = wready_q && !bd_wr;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign bid       = bid_q;
  assign arready   = arready_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign rlast     = rlast_q;
  assign rid       = rid_q;
  assign bd_rdata  = bd_rdata_q;
  assign init_done = init_done_q;

  // Single write port: fill, then backdoor, then AXI W beat.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = FILL;
    mem_ws = 4'hF;
    if (w_q == W_FILL) begin
      mem_we = !fill_done;
      mem_wa = fill_cnt_q[IW-1:0];
    end else if (bd_wr) begin
      mem_we = in_rng(bd_addr);
      mem_wa = widx(bd_addr);
      mem_wd = bd_wdata;
      mem_ws = bd_wstrb;
    end else if (w_beat) begin
      mem_we = w_ok;
      mem_wa = widx(waddr_q);
      mem_wd = wdata;
      mem_ws = wstrb;
    end
  end

  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (mem_we && mem_ws[b]) mem[mem_wa][8*b +: 8] <= mem_wd[8*b +: 8];

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fill_cnt_q  <= '0;
      init_done_q <= 1'b0;
      bd_rdata_q  <= '0;
    end else begin
      if (!fill_done) fill_cnt_q <= fill_cnt_q + CW'(1);
      if (fill_done) init_done_q <= 1'b1;
      if (bd_rd) bd_rdata_q <= in_rng(bd_addr) ? mem[widx(bd_addr)] : FILL;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      w_q       <= W_FILL;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      bid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      werr_q    <= 1'b0;
    end else begin
      case (w_q)
        W_FILL: if (fill_done) begin
          awready_q <= 1'b1;
          w_q       <= W_IDLE;
        end
        W_IDLE: if (awvalid && awready_q) begin
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          bid_q     <= awid;
          waddr_q   <= awaddr;
          wlen_q    <= awlen;
          wsize_q   <= awsize;
          wburst_q  <= awburst;
          wcnt_q    <= '0;
          werr_q    <= 1'b0;
          w_q       <= W_DATA;
        end
        W_DATA: if (w_beat) begin
          waddr_q <= next_addr(waddr_q, wsize_q, wburst_q);
          wcnt_q  <= wcnt_q + 8'd1;
          werr_q  <= werr_q || w_bad;
          if (wlast || w_end) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= (werr_q || w_bad) ? SLVERR : OKAY;
            w_q      <= W_RESP;
          end
        end
        W_RESP: if (bready) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          w_q       <= W_IDLE;
        end
      endcase
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_q       <= R_FILL;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= OKAY;
      rid_q     <= '0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
    end else begin
      case (r_q)
        R_FILL: if (fill_done) begin
          arready_q <= 1'b1;
          r_q       <= R_IDLE;
        end
        R_IDLE: if (arvalid && arready_q) begin
          arready_q <= 1'b0;
          rid_q     <= arid;
          raddr_q   <= araddr;
          rlen_q    <= arlen;
          rsize_q   <= arsize;
          rburst_q  <= arburst;
          rcnt_q    <= '0;
          r_q       <= R_FETCH;
        end
        R_FETCH: begin
          rdata_q  <= r_ok ? mem[widx(raddr_q)] : FILL;
          rresp_q  <= r_ok ? OKAY : SLVERR;
          rlast_q  <= rcnt_q == rlen_q;
          rvalid_q <= 1'b1;
          r_q      <= R_DATA;
        end
        R_DATA: if (rready) begin
          rvalid_q <= 1'b0;
          rlast_q  <= 1'b0;
          if (rlast_q) begin
            arready_q <= 1'b1;
            r_q       <= R_IDLE;
          end else begin
            rcnt_q  <= rcnt_q + 8'd1;
            raddr_q <= next_addr(raddr_q, rsize_q, rburst_q);
            r_q     <= R_FETCH;
          end
        end
      endcase
    end
endmodule
